// File: rtl/dcache_pkg.sv
// Shared types and default geometry for the direct-mapped L1 data cache.
package dcache_pkg;

  typedef enum logic [1:0] {
    StIdle      = 2'd0,
    StWriteback = 2'd1,
    StAllocate  = 2'd2
  } dcache_state_e;

  localparam int unsigned DC_OFF_W  = 3;
  localparam int unsigned DC_IDX_W  = 5;
  localparam int unsigned DC_TAG_W  = 32 - DC_IDX_W - DC_OFF_W - 2;
  localparam int unsigned DC_LINE_W = 32 * (1 << DC_OFF_W);

endpackage

// File: rtl/dcache_array.sv
// Flop-based tag/valid/dirty/data storage with asynchronous read.
// Refill beats a store-hit word write; valid/dirty clear asynchronously on rst_i.
module dcache_array
  import dcache_pkg::*;
#(
  parameter int unsigned NUM_LINES  = 32,
  parameter int unsigned LINE_WORDS = 8
) (
  input  logic                                          clk_i,
  input  logic                                          rst_i,
  input  logic [$clog2(NUM_LINES)-1:0]                  idx_i,
  output logic                                          rd_valid_o,
  output logic                                          rd_dirty_o,
  output logic [31-$clog2(NUM_LINES)-$clog2(LINE_WORDS)-2:0] rd_tag_o,
  output logic [32*LINE_WORDS-1:0]                      rd_line_o,
  input  logic                                          word_we_i,
  input  logic [$clog2(LINE_WORDS)-1:0]                 word_off_i,
  input  logic [31:0]                                   word_data_i,
  input  logic                                          fill_we_i,
  input  logic [31-$clog2(NUM_LINES)-$clog2(LINE_WORDS)-2:0] fill_tag_i,
  input  logic [32*LINE_WORDS-1:0]                      fill_line_i
);

  localparam int unsigned IdxW  = $clog2(NUM_LINES);
  localparam int unsigned OffW  = $clog2(LINE_WORDS);
  localparam int unsigned TagW  = 32 - IdxW - OffW - 2;
  localparam int unsigned LineW = 32 * LINE_WORDS;

  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] dirty_q;
  logic [TagW-1:0]      tag_q  [NUM_LINES];
  logic [LineW-1:0]     data_q [NUM_LINES];

  assign rd_valid_o = valid_q[idx_i];
  assign rd_dirty_o = dirty_q[idx_i];
  assign rd_tag_o   = tag_q[idx_i];
  assign rd_line_o  = data_q[idx_i];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_we_i) begin
      valid_q[idx_i] <= 1'b1;
      dirty_q[idx_i] <= 1'b0;
    end else if (word_we_i) begin
      dirty_q[idx_i] <= 1'b1;
    end
  end

  // Payload storage is deliberately left unreset.
  always_ff @(posedge clk_i) begin
    if (fill_we_i) begin
      tag_q[idx_i]  <= fill_tag_i;
      data_q[idx_i] <= fill_line_i;
    end else if (word_we_i) begin
      data_q[idx_i][32*word_off_i +: 32] <= word_data_i;
    end
  end

endmodule

// File: rtl/dcache_top.sv
// Direct-mapped write-back/write-allocate L1 D-cache with miss FSM.
// Optional access/miss counters when DCACHE_STATS_EN is defined.
module dcache_top
  import dcache_pkg::*;
#(
  parameter int unsigned NUM_LINES  = 32,
  parameter int unsigned LINE_WORDS = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      cpu_req_i,
  input  logic                      cpu_we_i,
  input  logic [31:0]               cpu_addr_i,
  input  logic [31:0]               cpu_wdata_i,
  output logic [31:0]               cpu_rdata_o,
  output logic                      cpu_stall_o,
  output logic                      mem_req_o,
  output logic                      mem_we_o,
  output logic [31:0]               mem_addr_o,
  output logic [32*LINE_WORDS-1:0]  mem_wdata_o,
  input  logic [32*LINE_WORDS-1:0]  mem_rdata_i,
  input  logic                      mem_ack_i
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]               acc_cnt_o,
  output logic [31:0]               miss_cnt_o
`endif
);

  localparam int unsigned OffW  = $clog2(LINE_WORDS);
  localparam int unsigned IdxW  = $clog2(NUM_LINES);
  localparam int unsigned TagW  = 32 - IdxW - OffW - 2;
  localparam int unsigned LineW = 32 * LINE_WORDS;

  dcache_state_e state_q, state_d;

  logic [OffW-1:0]  req_off;
  logic [IdxW-1:0]  req_idx;
  logic [TagW-1:0]  req_tag;
  logic             rd_valid, rd_dirty;
  logic [TagW-1:0]  rd_tag;
  logic [LineW-1:0] rd_line;
  logic             hit, idle, store_hit, fill_we, miss_start;
  logic             unused_addr;

  assign req_off     = cpu_addr_i[2 +: OffW];
  assign req_idx     = cpu_addr_i[2 + OffW +: IdxW];
  assign req_tag     = cpu_addr_i[31 -: TagW];
  assign unused_addr = ^cpu_addr_i[1:0];

  assign idle       = (state_q == StIdle);
  assign hit        = rd_valid && (rd_tag == req_tag);
  assign store_hit  = idle && cpu_req_i && cpu_we_i && hit;
  assign fill_we    = (state_q == StAllocate) && mem_ack_i;
  assign miss_start = idle && cpu_req_i && !hit;

  assign cpu_stall_o = !idle || miss_start;
  assign cpu_rdata_o = (idle && cpu_req_i && hit) ? rd_line[32*req_off +: 32] : 32'd0;

  dcache_array #(
    .NUM_LINES  (NUM_LINES),
    .LINE_WORDS (LINE_WORDS)
  ) u_array (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .idx_i       (req_idx),
    .rd_valid_o  (rd_valid),
    .rd_dirty_o  (rd_dirty),
    .rd_tag_o    (rd_tag),
    .rd_line_o   (rd_line),
    .word_we_i   (store_hit),
    .word_off_i  (req_off),
    .word_data_i (cpu_wdata_i),
    .fill_we_i   (fill_we),
    .fill_tag_i  (req_tag),
    .fill_line_i (mem_rdata_i)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (miss_start) state_d = (rd_valid && rd_dirty) ? StWriteback : StAllocate;
      end
      StWriteback: if (mem_ack_i) state_d = StAllocate;
      StAllocate:  if (mem_ack_i) state_d = StIdle;
      default:     state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Memory side decodes straight from state so reset drops the request at once.
  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = 32'd0;
    mem_wdata_o = '0;
    unique case (state_q)
      StWriteback: begin
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = {rd_tag, req_idx, {(OffW + 2){1'b0}}};
        mem_wdata_o = rd_line;
      end
      StAllocate: begin
        mem_req_o  = 1'b1;
        mem_addr_o = {req_tag, req_idx, {(OffW + 2){1'b0}}};
      end
      default: ;
    endcase
  end

`ifdef DCACHE_STATS_EN
  logic [31:0] acc_cnt_q, miss_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_cnt_q  <= 32'd0;
      miss_cnt_q <= 32'd0;
    end else begin
      if (cpu_req_i && !cpu_stall_o && (acc_cnt_q != 32'hFFFF_FFFF)) begin
        acc_cnt_q <= acc_cnt_q + 32'd1;
      end
      if (miss_start && (miss_cnt_q != 32'hFFFF_FFFF)) begin
        miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end

  assign acc_cnt_o  = acc_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dcache_top.sv
// Directed self-checking bench for dcache_top with a latency-programmable line memory.
module tb_dcache_top;

  localparam int unsigned LineW = 256;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b1;
  logic             cpu_req_i = 1'b0;
  logic             cpu_we_i = 1'b0;
  logic [31:0]      cpu_addr_i = 32'd0;
  logic [31:0]      cpu_wdata_i = 32'd0;
  logic [31:0]      cpu_rdata_o;
  logic             cpu_stall_o;
  logic             mem_req_o;
  logic             mem_we_o;
  logic [31:0]      mem_addr_o;
  logic [LineW-1:0] mem_wdata_o;
  logic [LineW-1:0] mem_rdata_i = '0;
  logic             mem_ack_i = 1'b0;
`ifdef DCACHE_STATS_EN
  logic [31:0]      acc_cnt_o;
  logic [31:0]      miss_cnt_o;
`endif

  dcache_top dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .cpu_req_i   (cpu_req_i),
    .cpu_we_i    (cpu_we_i),
    .cpu_addr_i  (cpu_addr_i),
    .cpu_wdata_i (cpu_wdata_i),
    .cpu_rdata_o (cpu_rdata_o),
    .cpu_stall_o (cpu_stall_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i),
    .mem_ack_i   (mem_ack_i)
`ifdef DCACHE_STATS_EN
    ,
    .acc_cnt_o   (acc_cnt_o),
    .miss_cnt_o  (miss_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;

  logic [LineW-1:0] mem_model [logic [31:0]];
  int               stalls;
  int               ntx;
  logic [31:0]      got;
  logic             tx_we    [8];
  logic [31:0]      tx_addr  [8];
  logic [LineW-1:0] tx_wdata [8];

  function automatic logic [LineW-1:0] pat(input logic [31:0] a);
    logic [LineW-1:0] p;
    for (int i = 0; i < 8; i++) p[32*i +: 32] = {a[15:0], 16'(i)};
    return p;
  endfunction

  // One CPU access; memory acks the Nth cycle of each request.
  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input int lat_wb, input int lat_fill);
    int  cnt;
    bit  done;
    stalls = 0;
    ntx    = 0;
    cnt    = 0;
    done   = 0;
    got    = 32'hDEAD_BEEF;
    @(negedge clk_i);
    cpu_req_i   = 1'b1;
    cpu_we_i    = we;
    cpu_addr_i  = addr;
    cpu_wdata_i = wdata;
    for (int cyc = 0; cyc < 100 && !done; cyc++) begin
      mem_ack_i = 1'b0;
      #1;
      if (mem_req_o) begin
        cnt++;
        if (cnt == (mem_we_o ? lat_wb : lat_fill)) begin
          mem_ack_i = 1'b1;
          cnt = 0;
          if (ntx < 8) begin
            tx_we[ntx]    = mem_we_o;
            tx_addr[ntx]  = mem_addr_o;
            tx_wdata[ntx] = mem_wdata_o;
          end
          ntx++;
          if (mem_we_o) mem_model[mem_addr_o] = mem_wdata_o;
          else mem_rdata_i = mem_model.exists(mem_addr_o) ? mem_model[mem_addr_o]
                                                          : pat(mem_addr_o);
        end
      end
      if (!cpu_stall_o) begin
        got  = cpu_rdata_o;
        done = 1;
      end else begin
        stalls++;
      end
      @(negedge clk_i);
    end
    cpu_req_i = 1'b0;
    mem_ack_i = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL access_timeout addr=%h: stall never released", addr);
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (2) @(negedge clk_i);
    #1;
    checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL rst_mem_req: got %b want 0", mem_req_o); end
    checks++; if (mem_we_o !== 1'b0) begin errors++; $display("FAIL rst_mem_we: got %b want 0", mem_we_o); end
    checks++; if (mem_addr_o !== 32'd0) begin errors++; $display("FAIL rst_mem_addr: got %h want 0", mem_addr_o); end
    checks++; if (mem_wdata_o !== '0) begin errors++; $display("FAIL rst_mem_wdata: got %h want 0", mem_wdata_o); end
    checks++; if (cpu_stall_o !== 1'b0) begin errors++; $display("FAIL rst_stall: got %b want 0", cpu_stall_o); end
    checks++; if (cpu_rdata_o !== 32'd0) begin errors++; $display("FAIL rst_rdata: got %h want 0", cpu_rdata_o); end
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic test_load_miss_clean();
    access(1'b0, 32'h48, 32'd0, 3, 3);
    checks++; if (ntx !== 1) begin errors++; $display("FAIL lm_ntx: got %0d want 1", ntx); end
    checks++; if (tx_addr[0] !== 32'h40) begin errors++; $display("FAIL lm_addr: got %h want 40", tx_addr[0]); end
    checks++; if (tx_we[0] !== 1'b0) begin errors++; $display("FAIL lm_we: got %b want 0", tx_we[0]); end
    checks++; if (stalls !== 4) begin errors++; $display("FAIL lm_stall: got %0d want 4", stalls); end
    checks++; if (got !== 32'h1234_5678) begin errors++; $display("FAIL lm_rdata: got %h want 12345678", got); end
  endtask

  task automatic test_load_hit();
    access(1'b0, 32'h44, 32'd0, 3, 3);
    checks++; if (ntx !== 0) begin errors++; $display("FAIL lh_ntx: got %0d want 0", ntx); end
    checks++; if (stalls !== 0) begin errors++; $display("FAIL lh_stall: got %0d want 0", stalls); end
    checks++; if (got !== 32'h0040_0001) begin errors++; $display("FAIL lh_rdata: got %h want 00400001", got); end
  endtask

  task automatic test_dirty_conflict();
    access(1'b1, 32'h44, 32'hA5A5_A5A5, 2, 3);
    checks++; if (stalls !== 0 || ntx !== 0) begin errors++; $display("FAIL sh_stall: got stall=%0d ntx=%0d want 0 0", stalls, ntx); end
    access(1'b0, 32'h440, 32'd0, 2, 3);
    checks++; if (ntx !== 2) begin errors++; $display("FAIL dc_ntx: got %0d want 2", ntx); end
    checks++; if (tx_we[0] !== 1'b1 || tx_addr[0] !== 32'h40) begin errors++; $display("FAIL dc_wb: got we=%b addr=%h want 1 40", tx_we[0], tx_addr[0]); end
    checks++; if (tx_wdata[0][63:32] !== 32'hA5A5_A5A5) begin errors++; $display("FAIL dc_wb_w1: got %h want a5a5a5a5", tx_wdata[0][63:32]); end
    checks++; if (tx_wdata[0][95:64] !== 32'h1234_5678) begin errors++; $display("FAIL dc_wb_w2: got %h want 12345678", tx_wdata[0][95:64]); end
    checks++; if (tx_we[1] !== 1'b0 || tx_addr[1] !== 32'h440) begin errors++; $display("FAIL dc_fill: got we=%b addr=%h want 0 440", tx_we[1], tx_addr[1]); end
    checks++; if (stalls !== 6) begin errors++; $display("FAIL dc_stall: got %0d want 6", stalls); end
    checks++; if (got !== 32'h0440_0000) begin errors++; $display("FAIL dc_rdata: got %h want 04400000", got); end
  endtask

  task automatic test_store_miss();
    access(1'b1, 32'h100, 32'hCAFE_F00D, 1, 1);
    checks++; if (ntx !== 1 || tx_we[0] !== 1'b0 || tx_addr[0] !== 32'h100) begin errors++; $display("FAIL sm_fill: got ntx=%0d we=%b addr=%h want 1 0 100", ntx, tx_we[0], tx_addr[0]); end
    checks++; if (stalls !== 2) begin errors++; $display("FAIL sm_stall: got %0d want 2", stalls); end
    access(1'b0, 32'h100, 32'd0, 1, 1);
    checks++; if (ntx !== 0 || stalls !== 0) begin errors++; $display("FAIL sm_hit: got ntx=%0d stall=%0d want 0 0", ntx, stalls); end
    checks++; if (got !== 32'hCAFE_F00D) begin errors++; $display("FAIL sm_rdata: got %h want cafef00d", got); end
`ifdef DCACHE_STATS_EN
    checks++; if (acc_cnt_o !== 32'd6) begin errors++; $display("FAIL stats_acc: got %0d want 6", acc_cnt_o); end
    checks++; if (miss_cnt_o !== 32'd3) begin errors++; $display("FAIL stats_miss: got %0d want 3", miss_cnt_o); end
`endif
    // Conflict on index 8 exposes the dirty bit set by the store miss.
    access(1'b0, 32'h500, 32'd0, 1, 1);
    checks++; if (ntx !== 2 || tx_we[0] !== 1'b1 || tx_addr[0] !== 32'h100) begin errors++; $display("FAIL sm_dirty_wb: got ntx=%0d we=%b addr=%h want 2 1 100", ntx, tx_we[0], tx_addr[0]); end
    checks++; if (tx_wdata[0][31:0] !== 32'hCAFE_F00D) begin errors++; $display("FAIL sm_wb_data: got %h want cafef00d", tx_wdata[0][31:0]); end
    checks++; if (stalls !== 3) begin errors++; $display("FAIL sm_wb_stall: got %0d want 3", stalls); end
  endtask

  task automatic test_reset_mid_allocate();
    bit seen;
    seen = 0;
    @(negedge clk_i);
    cpu_req_i  = 1'b1;
    cpu_we_i   = 1'b0;
    cpu_addr_i = 32'h48;
    for (int i = 0; i < 10 && !seen; i++) begin
      #1;
      if (mem_req_o) seen = 1;
      else @(negedge clk_i);
    end
    checks++; if (!seen) begin errors++; $display("FAIL rm_req_seen: got 0 want 1"); end
    #2;
    rst_i = 1'b1;
    #1;
    checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL rm_req_drop: got %b want 0", mem_req_o); end
    checks++; if (mem_addr_o !== 32'd0) begin errors++; $display("FAIL rm_addr: got %h want 0", mem_addr_o); end
    @(negedge clk_i);
    cpu_req_i = 1'b0;
    #1;
    checks++; if (cpu_stall_o !== 1'b0) begin errors++; $display("FAIL rm_idle_stall: got %b want 0", cpu_stall_o); end
    @(negedge clk_i);
    rst_i = 1'b0;
    access(1'b0, 32'h48, 32'd0, 1, 2);
    checks++; if (ntx !== 1 || tx_addr[0] !== 32'h40 || tx_we[0] !== 1'b0) begin errors++; $display("FAIL rm_remiss: got ntx=%0d addr=%h we=%b want 1 40 0", ntx, tx_addr[0], tx_we[0]); end
    checks++; if (stalls !== 3) begin errors++; $display("FAIL rm_stall: got %0d want 3", stalls); end
    checks++; if (got !== 32'h1234_5678) begin errors++; $display("FAIL rm_rdata: got %h want 12345678", got); end
  endtask

  initial begin
    logic [LineW-1:0] l40;
    l40 = pat(32'h40);
    l40[95:64] = 32'h1234_5678;
    mem_model[32'h40] = l40;
    test_reset();
    test_load_miss_clean();
    test_load_hit();
    test_dirty_conflict();
    test_store_miss();
    test_reset_mid_allocate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dcache_top.md
# dcache_top

Direct-mapped, write-back, write-allocate L1 data cache between the pipeline's MEM stage and a slow line-wide backing memory. It replaces the single-cycle data memory port: hits complete in the access cycle, and misses stall the whole pipeline through `cpu_stall_o` while a controller FSM writes back a dirty victim and refills the line.

## Interface
Parameters:
- `NUM_LINES`, 32: number of cache lines (power of two).
- `LINE_WORDS`, 8: 32-bit words per line (power of two); line width `LINE_W = 32*LINE_WORDS`.

Ports:
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset. One clock; reset is asynchronous and active-high.
- `cpu_req_i`  in  1  MEM-stage access valid. Held with its address and data until `cpu_stall_o` is low.
- `cpu_we_i`  in  1  1 = store, 0 = load.
- `cpu_addr_i`  in  32  byte address; bits [1:0] are ignored.
- `cpu_wdata_i`  in  32  store data.
- `cpu_rdata_o`  out  32  load data, combinational, valid when `cpu_req_i & !cpu_stall_o`.
- `cpu_stall_o`  out  1  freeze the pipeline.
- `mem_req_o`  out  1  backing memory request.
- `mem_we_o`  out  1  1 = line write-back, 0 = line fetch.
- `mem_addr_o`  out  32  line-aligned address.
- `mem_wdata_o`  out  LINE_W  victim line.
- `mem_rdata_i`  in  LINE_W  fetched line, valid with `mem_ack_i`.
- `mem_ack_i`  in  1  one-cycle completion pulse.

## Operation
Address split (defaults):
- offset = [4:2], word select
- index = [9:5]
- tag = [31:10], 22 bits

Widths derive from the parameters via `$clog2`.

Line state: `valid` bit, `dirty` bit, tag, and data, all held in flops.

FSM states: IDLE, WRITEBACK, ALLOCATE.
- IDLE, hit (`valid & tag match`):
  - `cpu_stall_o=0`.
  - Load: returns the selected word.
  - Store: writes the word at the clock edge and sets `dirty`.
- IDLE, `cpu_req_i` with a miss:
  - `cpu_stall_o=1` in the same cycle.
  - Next state is WRITEBACK if the victim is `valid & dirty`, otherwise ALLOCATE.
- WRITEBACK:
  - Drives `mem_req_o=1`, `mem_we_o=1`, `mem_addr_o={victim tag, index, 0}`, `mem_wdata_o` = victim line.
  - On `mem_ack_i` → ALLOCATE.
- ALLOCATE:
  - Drives `mem_req_o=1`, `mem_we_o=0`, `mem_addr_o={req tag, index, 0}`.
  - On `mem_ack_i`: writes `mem_rdata_i` into the line, sets tag, `valid=1`, `dirty=0`, → IDLE.
- The held request retries in IDLE and now hits. A store miss therefore completes as a normal store hit and sets `dirty`.
- `cpu_stall_o` is 1 in WRITEBACK and ALLOCATE regardless of `cpu_req_i`.
- `cpu_req_i=0` in IDLE: no state change, `cpu_stall_o=0`.

## Timing
- Reset values:
  - State IDLE; all `valid` and `dirty` bits 0.
  - `mem_req_o=0`, `mem_we_o=0`, `mem_addr_o=0`, `mem_wdata_o=0`, `cpu_stall_o=0`, `cpu_rdata_o=0`.
  - Data and tag arrays are not reset.
- Hit latency: 0 extra cycles.
- Clean miss: stall cycles = memory latency N (request to ack, inclusive) + 1 retry cycle. For example, with ack in the 3rd request cycle, stall is high for 4 cycles.
- Dirty miss: stall cycles = N_wb + N_fill + 1.
- Memory handshake:
  - `mem_req_o`, `mem_we_o`, `mem_addr_o` and `mem_wdata_o` stay stable from assertion through the ack cycle.
  - `mem_req_o` drops or changes type the cycle after the ack; WRITEBACK→ALLOCATE has no idle gap.
  - `mem_ack_i` outside WRITEBACK/ALLOCATE is ignored.
- Reset mid-operation: the outstanding transaction is abandoned, `mem_req_o` falls asynchronously, and all lines are invalidated. Memory must tolerate the abandoned request.
- Outputs in IDLE: `mem_*` outputs are 0 whenever the state is IDLE.

## Configuration
- Macro `DCACHE_STATS_EN`.
- When defined: adds outputs `acc_cnt_o[31:0]` and `miss_cnt_o[31:0]`.
  - `acc_cnt_o` increments on each completed access (`cpu_req_i & !cpu_stall_o`).
  - `miss_cnt_o` increments on each IDLE→WRITEBACK/ALLOCATE transition.
  - Both saturate at 0xFFFFFFFF and reset to 0.
- When undefined: the ports and counters are absent; behaviour is otherwise identical.

## Structure
- Package `dcache_pkg`:
  - State enum `dcache_state_e` (IDLE, WRITEBACK, ALLOCATE).
  - Default width constants: `DC_TAG_W`, `DC_IDX_W`, `DC_OFF_W`, `DC_LINE_W`.
- Sub-module `dcache_array`:
  - Tag/valid/dirty/data storage with asynchronous read.
  - Write ports: one word write (store hit) and one line write (refill); the refill port has priority.
  - Asynchronous clear of valid/dirty on `rst_i`.
- `dcache_top` holds the FSM, hit logic, muxing and the optional counters.

## Test plan
- **Load miss, clean line:** after reset, load 0x48; memory acks 3 cycles after request with word2=0x12345678. Expect:
  - `mem_addr_o=0x40`, `mem_we_o=0`.
  - Stall for 4 cycles.
  - `cpu_rdata_o=0x12345678`.
- **Load hit:** load 0x44 next. Expect no `mem_req_o`, `cpu_stall_o=0`, and word1 of the fetched line returned.
- **Store hit then dirty conflict miss:**
  - Store 0xA5A5A5A5 to 0x44; then load 0x440 (same index 2, tag 1).
  - Expect a write-back to 0x40 with `mem_wdata_o` word1=0xA5A5A5A5, then a fetch of 0x440.
  - Stall = N_wb+N_fill+1.
- **Store miss to a clean invalid line:**
  - Store 0xCAFEF00D to 0x100.
  - Expect a fetch of 0x100, then the line marked dirty.
  - A later load of 0x100 returns 0xCAFEF00D with no memory traffic.
- **Reset mid-ALLOCATE:**
  - Assert `rst_i` while `mem_req_o=1`.
  - Expect `mem_req_o=0` immediately and state IDLE.
  - A reload of 0x48 misses again.
- **`DCACHE_STATS_EN` defined:** the first four scenarios' accesses yield `acc_cnt_o=6`, `miss_cnt_o=3`.
